// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: B-type opcode, PC-select redirect
// codes and the reset value of a direction counter.
package bp_pkg;

  localparam logic [4:0] B_TYPE        = 5'b11000;
  localparam logic [2:0] PCSEL_PC4     = 3'd0;
  localparam logic [2:0] PCSEL_PCD_IMM = 3'd3;
  localparam logic [2:0] PCSEL_PCD_4   = 3'd4;

  // Weakly not-taken: one below the taken threshold (0 for a 1-bit counter).
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bht_branch_predictor_sat_counter.sv
// Saturating up/down counter holding one direction-table entry; counts toward
// taken on inc=1 and toward not-taken on inc=0 when enabled.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned INIT_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  output logic [CTR_W-1:0] count
);

  localparam logic [CTR_W-1:0] MAX_C = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] MIN_C = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] ONE_C = CTR_W'(1);

  logic [CTR_W-1:0] count_r;
  logic [CTR_W-1:0] next_s;

  // Next value: step toward the outcome, clamped at both ends.
  always_comb begin
    next_s = count_r;
    if (inc) begin
      if (count_r != MAX_C) next_s = count_r + ONE_C;
      else                  next_s = count_r;
    end else begin
      if (count_r != MIN_C) next_s = count_r - ONE_C;
      else                  next_s = count_r;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n)  count_r <= CTR_W'(INIT_VAL);
    else if (en) count_r <= next_s;
    else         count_r <= count_r;
  end

  assign count = count_r;

endmodule

// File: rtl/bht_branch_predictor.sv
// Table-based branch direction predictor (bimodal or gshare) with misprediction
// redirect/kill generation and saturating branch/mispredict statistics.
module bht_branch_predictor
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CTR_W   = 2,
  parameter  int unsigned GHR_W   = 0,
  parameter  int unsigned PC_W    = 32,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  input  logic             pred_is_branch_i,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             mispredict_o,
  output logic [2:0]       redirect_sel_o,
  output logic             killD_req_o,
  output logic             killD2_req_o,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      mispred_cnt_o
);

  logic [CTR_W-1:0] ctr_s [ENTRIES];
  logic [IDX_W-1:0] hist_s;
  logic [IDX_W-1:0] idx_s;
  logic             mispred_s;
  logic [31:0]      branch_cnt_r;
  logic [31:0]      mispred_cnt_r;
  logic             unused_pc_s;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_tab
    sat_counter #(
      .CTR_W   (CTR_W),
      .INIT_VAL(ctr_init(CTR_W))
    ) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (upd_valid_i && (upd_idx_i == IDX_W'(i))),
      .inc  (upd_taken_i),
      .count(ctr_s[i])
    );
  end

  if (GHR_W > 0) begin : g_ghr
    logic [GHR_W-1:0] ghr_r;

    // Non-speculative history: shifted only by resolved outcomes.
    always_ff @(posedge clk) begin
      if (!rst_n)           ghr_r <= {GHR_W{1'b0}};
      else if (upd_valid_i) ghr_r <= GHR_W'({ghr_r, upd_taken_i});
      else                  ghr_r <= ghr_r;
    end

    // History zero-extended into the low index bits.
    always_comb begin
      hist_s              = {IDX_W{1'b0}};
      hist_s[GHR_W-1:0]   = ghr_r;
    end
  end else begin : g_no_ghr
    assign hist_s = {IDX_W{1'b0}};
  end

  assign idx_s       = pred_pc_i[IDX_W+1:2] ^ hist_s;
  assign unused_pc_s = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

  // Prediction and resolution outputs, all gated by their valid inputs.
  always_comb begin
    pred_idx_o     = {IDX_W{1'b0}};
    pred_taken_o   = 1'b0;
    mispred_s      = 1'b0;
    redirect_sel_o = PCSEL_PC4;
    if (pred_valid_i) begin
      pred_idx_o   = idx_s;
      pred_taken_o = pred_is_branch_i & ctr_s[idx_s][CTR_W-1];
    end else begin
      pred_idx_o   = {IDX_W{1'b0}};
      pred_taken_o = 1'b0;
    end
    if (upd_valid_i && (upd_taken_i != upd_pred_i)) begin
      mispred_s      = 1'b1;
      redirect_sel_o = upd_taken_i ? PCSEL_PCD_IMM : PCSEL_PCD_4;
    end else begin
      mispred_s      = 1'b0;
      redirect_sel_o = PCSEL_PC4;
    end
  end

  assign mispredict_o = mispred_s;
  assign killD_req_o  = mispred_s;
  assign killD2_req_o = mispred_s;

  // Statistics: increment per event, hold once all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (upd_valid_i && (branch_cnt_r != 32'hFFFF_FFFF)) branch_cnt_r <= branch_cnt_r + 32'd1;
      else                                                 branch_cnt_r <= branch_cnt_r;
      if (mispred_s && (mispred_cnt_r != 32'hFFFF_FFFF))  mispred_cnt_r <= mispred_cnt_r + 32'd1;
      else                                                 mispred_cnt_r <= mispred_cnt_r;
    end
  end

  assign branch_cnt_o  = branch_cnt_r;
  assign mispred_cnt_o = mispred_cnt_r;

endmodule
